// File: rtl/instr_fetch.sv
// Instruction fetch stage for the single-cycle MIPS datapath.
// Holds the PC, reads the instruction ROM combinationally and selects the
// next PC (sequential, beq, j/jal, jr).
// Optional feature macro: IFU_FAULT_EN adds a RUN/HALT FSM with a sticky
// fetch fault on misaligned or out-of-range next-PC values.
module instr_fetch #(
    parameter logic [31:0] PC_BASE  = 32'h0000_3000,
    parameter int unsigned IM_DEPTH = 1024,
    parameter string       IM_FILE  = "code.txt"
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_cw_pc_enable,
    input  logic        i_cw_im_enable,
    input  logic [2:0]  i_cw_npc_jump_mode,
    input  logic        i_branch_taken,
    input  logic [31:0] i_jr_target,
    output logic [31:0] o_curr_instr,
    output logic [31:0] o_curr_pc,
    output logic [31:0] o_link_addr,
    output logic        o_fetch_fault
);

    localparam int unsigned AW = $clog2(IM_DEPTH);

    logic [31:0]   r_im [IM_DEPTH];
    logic [31:0]   r_pc;
    logic [31:0]   w_pc_next;
    logic [31:0]   w_offset;
    logic [AW-1:0] w_idx;
    logic [31:0]   w_p4;
    logic [31:0]   w_br_off;
    logic [31:0]   w_npc;
    logic          w_halted;

    assign w_offset = r_pc - PC_BASE;
    assign w_idx    = w_offset[AW+1:2];

    // Combinational IM read; disabled or halted fetch issues a nop
    always_comb begin
        o_curr_instr = 32'h0;
        if (i_cw_im_enable && !w_halted) o_curr_instr = r_im[w_idx];
    end

    assign w_p4     = r_pc + 32'd4;
    assign w_br_off = {{14{o_curr_instr[15]}}, o_curr_instr[15:0], 2'b00};

    // Next-PC select
    always_comb begin
        w_npc = w_p4;
        case (i_cw_npc_jump_mode)
            3'd1:    w_npc = i_branch_taken ? (w_p4 + w_br_off) : w_p4;
            3'd2:    w_npc = {r_pc[31:28], o_curr_instr[25:0], 2'b00};
            3'd3:    w_npc = i_jr_target;
            default: w_npc = w_p4;
        endcase
    end

    assign o_curr_pc   = r_pc;
    assign o_link_addr = w_p4;

`ifdef IFU_FAULT_EN
    typedef enum logic {StRun, StHalt} state_t;

    localparam logic [32:0] IM_LIMIT = {1'b0, PC_BASE} + 33'(4 * IM_DEPTH);

    state_t r_state;
    state_t w_state_next;
    logic   r_fault;
    logic   w_npc_bad;
    logic   w_fault_set;
    logic   w_unused_bits;

    assign w_npc_bad = (w_npc[1:0] != 2'b00) || (w_npc < PC_BASE) ||
                       ({1'b0, w_npc} >= IM_LIMIT);
    assign w_halted  = (r_state == StHalt);
    assign o_fetch_fault = r_fault;
    assign w_unused_bits = ^{w_offset[31:AW+2], w_offset[1:0]};

    // Next state: a bad target halts fetch instead of loading the PC
    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_fault_set  = 1'b0;
        if (r_state == StRun && i_cw_pc_enable) begin
            if (w_npc_bad) begin
                w_state_next = StHalt;
                w_fault_set  = 1'b1;
            end else begin
                w_pc_next = w_npc;
            end
        end
    end

    // State, PC and sticky fault registers
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= StRun;
            r_pc    <= PC_BASE;
            r_fault <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            r_fault <= r_fault | w_fault_set;
        end
    end
`else
    logic w_unused_bits;

    assign w_halted      = 1'b0;
    assign o_fetch_fault = 1'b0;
    assign w_unused_bits = ^{w_offset[31:AW+2], w_offset[1:0], w_npc[1:0]};

    // Word-align the target; out-of-range PCs simply alias into the ROM
    always_comb begin
        w_pc_next = r_pc;
        if (i_cw_pc_enable) w_pc_next = {w_npc[31:2], 2'b00};
    end

    // PC register
    always_ff @(posedge i_clk) begin
        if (i_reset) r_pc <= PC_BASE;
        else         r_pc <= w_pc_next;
    end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: ROM preloaded through the hierarchy,
// linear stimulus, hand-computed expectations.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        pc_en;
    logic        im_en;
    logic [2:0]  mode;
    logic        taken;
    logic [31:0] jr_t;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] link;
    logic        fault;

    int checks   = 0;
    int failures = 0;

    instr_fetch #(
        .PC_BASE (32'h0000_3000),
        .IM_DEPTH(1024),
        .IM_FILE ("")
    ) dut (
        .i_clk             (clk),
        .i_reset           (reset),
        .i_cw_pc_enable    (pc_en),
        .i_cw_im_enable    (im_en),
        .i_cw_npc_jump_mode(mode),
        .i_branch_taken    (taken),
        .i_jr_target       (jr_t),
        .o_curr_instr      (instr),
        .o_curr_pc         (pc),
        .o_link_addr       (link),
        .o_fetch_fault     (fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int k = 0; k < 1024; k++) dut.r_im[k] = 32'hA000_0000 | k;
        dut.r_im[7]  = 32'h114A_FFF9;  // beq, offset -7 at 0x301C
        dut.r_im[8]  = 32'h0800_0C10;  // j 0x3040 at 0x3020
        dut.r_im[64] = 32'h1000_FFFF;  // beq, offset -1 at 0x3100

        reset = 1'b1; pc_en = 1'b0; im_en = 1'b1; mode = 3'd0; taken = 1'b0; jr_t = 32'h0;
        step();
        chk("reset_pc", pc, 32'h3000);
        chk("reset_instr", instr, 32'hA000_0000);
        chk("reset_link", link, 32'h3004);
        chk("reset_fault", {31'b0, fault}, 32'h0);

        reset = 1'b0; pc_en = 1'b1;
        step(); chk("seq_1", pc, 32'h3004);
        chk("seq_1_instr", instr, 32'hA000_0001);
        step(); chk("seq_2", pc, 32'h3008);
        step(); chk("seq_3", pc, 32'h300C);
        chk("seq_3_link", link, 32'h3010);
        pc_en = 1'b0;
        step(); chk("hold", pc, 32'h300C);

        pc_en = 1'b1; mode = 3'd3; jr_t = 32'h301C;
        step(); chk("jr_301c", pc, 32'h301C);
        chk("beq_instr", instr, 32'h114A_FFF9);
        mode = 3'd1; taken = 1'b1;
        step(); chk("beq_taken", pc, 32'h3004);
        mode = 3'd3;
        step();
        mode = 3'd1; taken = 1'b0;
        step(); chk("beq_not_taken", pc, 32'h3020);
        chk("j_instr", instr, 32'h0800_0C10);
        mode = 3'd2;
        step(); chk("j_target", pc, 32'h3040);
        mode = 3'd3; jr_t = 32'h3100;
        step(); chk("jr_3100", pc, 32'h3100);
        chk("self_instr", instr, 32'h1000_FFFF);
        mode = 3'd1; taken = 1'b1;
        step(); chk("beq_self_loop", pc, 32'h3100);
        mode = 3'd7; taken = 1'b0;
        step(); chk("mode_other_p4", pc, 32'h3104);

        pc_en = 1'b0; mode = 3'd3; jr_t = 32'h3200;
        step(); chk("hold_mode3", pc, 32'h3104);
        im_en = 1'b0; #1;
        chk("im_disable", instr, 32'h0);
        im_en = 1'b1; #1;
        chk("im_enable", instr, 32'hA000_0041);

        pc_en = 1'b1; jr_t = 32'h3040;
        step(); chk("pre_reset_pc", pc, 32'h3040);
        reset = 1'b1;
        step(); chk("mid_reset", pc, 32'h3000);
        reset = 1'b0;

`ifdef IFU_FAULT_EN
        jr_t = 32'h3102;
        step(); chk("fault_misalign_pc", pc, 32'h3000);
        chk("fault_misalign_flag", {31'b0, fault}, 32'h1);
        chk("fault_halt_instr", instr, 32'h0);
        mode = 3'd0;
        step(); chk("fault_frozen", pc, 32'h3000);
        chk("fault_sticky", {31'b0, fault}, 32'h1);
        reset = 1'b1;
        step(); chk("fault_reset_pc", pc, 32'h3000);
        chk("fault_reset_flag", {31'b0, fault}, 32'h0);
        reset = 1'b0; mode = 3'd3; jr_t = 32'h3FFC;
        step(); chk("last_word", pc, 32'h3FFC);
        mode = 3'd0;
        step(); chk("past_end_pc", pc, 32'h3FFC);
        chk("past_end_flag", {31'b0, fault}, 32'h1);
`else
        jr_t = 32'h3102;
        step(); chk("align_force", pc, 32'h3100);
        chk("no_fault", {31'b0, fault}, 32'h0);
        jr_t = 32'h3FFC;
        step(); chk("last_word", pc, 32'h3FFC);
        chk("last_instr", instr, 32'hA000_03FF);
        mode = 3'd0;
        step(); chk("fall_through", pc, 32'h4000);
        chk("alias_instr", instr, 32'hA000_0000);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
